// File: rtl/sum_req_initiator.sv
// ---------------------------------------------------------------------------
// sum_req_initiator
//
// Purpose:
//   Initiator side of the single-cycle start/valid adder protocol. Takes
//   operand pairs from an upstream ready/valid stream and sends each pair to
//   an adder responder with a one-cycle start pulse. It then waits a bounded
//   number of cycles for the responder's valid, captures the sum, and returns
//   it downstream over a ready/valid stream. If no valid arrives in time, a
//   zero sum with the error flag set is returned instead, so the pipeline
//   cannot hang.
//
// Optional feature (macro SUM_INIT_CHECK_EN):
//   When defined, the block recomputes req_a+req_b locally and flags out_err
//   when the responder's sum disagrees. The responder's value is still
//   returned. When undefined, out_err reports timeouts only.
//
// Parameters:
//   W        operand/result width in bits
//   TIMEOUT  max cycles in WAIT without rsp_valid before timeout (>=2)
//   CNT_W    width of the wait counter
//
// Ports:
//   i_clk        clock, all logic on rising edge
//   i_rst_n      synchronous active-low reset
//   i_in_valid   upstream operand pair valid
//   o_in_ready   upstream ready (only in IDLE and out of reset)
//   i_in_a/b     operands
//   o_req_start  one-cycle start pulse to responder
//   o_req_a/b    operands to responder, held until next accept
//   i_rsp_valid  responder valid
//   i_rsp_y      responder sum
//   o_out_valid  result valid
//   i_out_ready  downstream ready
//   o_out_sum    captured sum (0 on timeout)
//   o_out_err    result is a timeout (or a check failure with the feature)
//   o_spurious   sticky: rsp_valid seen outside WAIT
// ---------------------------------------------------------------------------
module sum_req_initiator #(
  parameter int W       = 12,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_a,
  input  logic [W-1:0] i_in_b,
  output logic         o_req_start,
  output logic [W-1:0] o_req_a,
  output logic [W-1:0] o_req_b,
  input  logic         i_rsp_valid,
  input  logic [W-1:0] i_rsp_y,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_sum,
  output logic         o_out_err,
  output logic         o_spurious
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           r_state;
  logic             r_req_start;
  logic [W-1:0]     r_req_a;
  logic [W-1:0]     r_req_b;
  logic             r_out_valid;
  logic [W-1:0]     r_out_sum;
  logic             r_out_err;
  logic             r_spurious;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_timeout;
  logic             w_rsp_err;

  // Ready is only offered from IDLE, and is forced low while reset is held
  // so nothing is accepted on the same edge that reset is sampled.
  assign o_in_ready = i_rst_n && (r_state == S_IDLE);
  assign w_accept   = i_in_valid && o_in_ready;

  // The counter starts at zero on the accept edge, so the last WAIT edge is
  // the one where it reads TIMEOUT-1; that gives exactly TIMEOUT WAIT edges.
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

`ifdef SUM_INIT_CHECK_EN
  logic [W-1:0] w_expected;

  // Local reference sum of the operands still held on the request bus. It
  // wraps at W bits exactly like the responder's result.
  assign w_expected = r_req_a + r_req_b;
  assign w_rsp_err  = (i_rsp_y != w_expected);
`else
  assign w_rsp_err  = 1'b0;
`endif

  // Single controller for the whole transaction. Everything visible on the
  // ports is registered here so the responder and the downstream consumer
  // only ever see clean, edge-aligned values. A response always beats a
  // timeout that lands on the same edge, because the responder did answer
  // within the window. Any valid seen outside WAIT is recorded as spurious
  // and otherwise ignored, including a late answer after a timeout.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_req_start <= 1'b0;
      r_req_a     <= '0;
      r_req_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_err   <= 1'b0;
      r_spurious  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_start <= 1'b0;
          if (w_accept) begin
            r_req_a     <= i_in_a;
            r_req_b     <= i_in_b;
            r_req_start <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_req_start <= 1'b0;
          r_cnt       <= r_cnt + CNT_W'(1);
          if (i_rsp_valid) begin
            r_out_sum   <= i_rsp_y;
            r_out_err   <= w_rsp_err;
            r_out_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_out_sum   <= '0;
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_req_start <= 1'b0;
          if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_req_start <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase

      if (i_rsp_valid && (r_state != S_WAIT)) begin
        r_spurious <= 1'b1;
      end
    end
  end

  assign o_req_start = r_req_start;
  assign o_req_a     = r_req_a;
  assign o_req_b     = r_req_b;
  assign o_out_valid = r_out_valid;
  assign o_out_sum   = r_out_sum;
  assign o_out_err   = r_out_err;
  assign o_spurious  = r_spurious;

endmodule

// File: tb/tb_sum_req_initiator.sv
// ---------------------------------------------------------------------------
// tb_sum_req_initiator
//
// Directed bench for sum_req_initiator with default parameters (W=12,
// TIMEOUT=8). A table of operand pairs with responder delay, responder sum
// and hand-computed results is run in a loop; the timeout/late-valid and
// reset-in-WAIT cases are written out by hand afterwards.
// ---------------------------------------------------------------------------
module tb_sum_req_initiator;

  localparam int W       = 12;
  localparam int TIMEOUT = 8;

`ifdef SUM_INIT_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic         clk;
  logic         rstN;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         reqStart;
  logic [W-1:0] reqA;
  logic [W-1:0] reqB;
  logic         rspValid;
  logic [W-1:0] rspY;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] outSum;
  logic         outErr;
  logic         spurious;

  int checkCount;
  int passCount;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           rspDelay;
    logic [W-1:0] rspVal;
    logic [W-1:0] expSum;
    logic         expErr;
    int           expLat;
    int           bpCycles;
  } vec_t;

  vec_t vecs[7];

  sum_req_initiator #(
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_in_a      (inA),
    .i_in_b      (inB),
    .o_req_start (reqStart),
    .o_req_a     (reqA),
    .o_req_b     (reqB),
    .i_rsp_valid (rspValid),
    .i_rsp_y     (rspY),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_sum   (outSum),
    .o_out_err   (outErr),
    .o_spurious  (spurious)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and prints a FAIL line on disagreement.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one operand pair, plays a responder that answers rspDelay cycles
  // after the accept edge (negative means never), and checks the request
  // pulse, the result latency and the captured result. Leaves the DUT in
  // RESP with the result still pending.
  task automatic applyStimulus(input vec_t v);
    int lat;
    int waitCyc;
    waitCyc = 0;
    while (!inReady && waitCyc < 10) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    checkOutput("in_ready before accept", 32'(inReady), 32'd1);

    inValid = 1'b1;
    inA     = v.a;
    inB     = v.b;
    @(posedge clk); #1;
    inValid = 1'b0;
    checkOutput("req_start after accept", 32'(reqStart), 32'd1);
    checkOutput("req_a issued", 32'(reqA), 32'(v.a));
    checkOutput("req_b issued", 32'(reqB), 32'(v.b));
    checkOutput("in_ready low in WAIT", 32'(inReady), 32'd0);

    lat = -1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      rspValid = (cyc == v.rspDelay);
      rspY     = (cyc == v.rspDelay) ? v.rspVal : '0;
      if (cyc == 1) begin
        checkOutput("req_start one cycle", 32'(reqStart), 32'd0);
        checkOutput("req_a held", 32'(reqA), 32'(v.a));
      end
      if (outValid) begin
        lat = cyc;
        break;
      end
    end
    rspValid = 1'b0;
    rspY     = '0;

    checkOutput("result latency", 32'(lat), 32'(v.expLat));
    checkOutput("out_sum", 32'(outSum), 32'(v.expSum));
    checkOutput("out_err", 32'(outErr), 32'(v.expErr));
  endtask

  // Holds the result under backpressure for bpCycles, checking it stays put,
  // then completes the handshake and checks the return to IDLE.
  task automatic drainResult(input int bpCycles, input logic [W-1:0] expSum,
                             input logic expErr);
    for (int i = 0; i < bpCycles; i++) begin
      @(posedge clk); #1;
      checkOutput("bp out_valid held", 32'(outValid), 32'd1);
      checkOutput("bp out_sum stable", 32'(outSum), 32'(expSum));
      checkOutput("bp out_err stable", 32'(outErr), 32'(expErr));
      checkOutput("bp in_ready low", 32'(inReady), 32'd0);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    checkOutput("out_valid dropped", 32'(outValid), 32'd0);
    checkOutput("in_ready after drain", 32'(inReady), 32'd1);
  endtask

  // Main sequence: reset, table of transactions, then the hand-written
  // timeout/late-valid and reset-in-WAIT corner cases.
  initial begin
    vec_t tv;
    checkCount = 0;
    passCount  = 0;
    rstN       = 1'b0;
    inValid    = 1'b0;
    inA        = '0;
    inB        = '0;
    rspValid   = 1'b0;
    rspY       = '0;
    outReady   = 1'b0;

    vecs[0] = '{12'h123, 12'h0FF, 1, 12'h222, 12'h222, 1'b0, 2, 0};
    vecs[1] = '{12'hFFF, 12'h002, 1, 12'h001, 12'h001, 1'b0, 2, 5};
    vecs[2] = '{12'h555, 12'h0AA, 3, 12'h5FF, 12'h5FF, 1'b0, 4, 1};
    vecs[3] = '{12'h0AB, 12'h011, 7, 12'h0BC, 12'h0BC, 1'b0, 8, 0};
    vecs[4] = '{12'h100, 12'h100, 1, 12'h300, 12'h300, CHK,  2, 0};
    vecs[5] = '{12'h100, 12'h100, 1, 12'h200, 12'h200, 1'b0, 2, 0};
    vecs[6] = '{12'h800, 12'h800, 2, 12'h000, 12'h000, 1'b0, 3, 2};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(inReady), 32'd0);
    checkOutput("reset req_start", 32'(reqStart), 32'd0);
    checkOutput("reset req_a", 32'(reqA), 32'd0);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset out_sum", 32'(outSum), 32'd0);
    checkOutput("reset out_err", 32'(outErr), 32'd0);
    checkOutput("reset spurious", 32'(spurious), 32'd0);
    rstN = 1'b1;
    #1;
    checkOutput("in_ready after reset", 32'(inReady), 32'd1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      drainResult(vecs[i].bpCycles, vecs[i].expSum, vecs[i].expErr);
    end
    checkOutput("no spurious after table", 32'(spurious), 32'd0);

    // Responder stays silent: timeout after 8 WAIT edges, then a late valid
    // arrives while the error result is still pending.
    tv = '{12'h040, 12'h001, -1, 12'h000, 12'h000, 1'b1, TIMEOUT, 0};
    applyStimulus(tv);
    @(posedge clk); #1;
    rspValid = 1'b1;
    rspY     = 12'h777;
    @(posedge clk); #1;
    rspValid = 1'b0;
    rspY     = '0;
    checkOutput("late valid spurious", 32'(spurious), 32'd1);
    checkOutput("late valid out_sum", 32'(outSum), 32'd0);
    checkOutput("late valid out_err", 32'(outErr), 32'd1);
    drainResult(1, 12'h000, 1'b1);
    checkOutput("spurious sticky", 32'(spurious), 32'd1);

    // Reset while in WAIT drops the pending request.
    inValid = 1'b1;
    inA     = 12'h321;
    inB     = 12'h123;
    @(posedge clk); #1;
    inValid = 1'b0;
    checkOutput("rst-wait req_start", 32'(reqStart), 32'd1);
    @(posedge clk); #1;
    rstN = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst-wait out_valid", 32'(outValid), 32'd0);
    checkOutput("rst-wait req_start low", 32'(reqStart), 32'd0);
    checkOutput("rst-wait req_a", 32'(reqA), 32'd0);
    checkOutput("rst-wait spurious", 32'(spurious), 32'd0);
    checkOutput("rst-wait in_ready", 32'(inReady), 32'd0);
    rstN = 1'b1;
    #1;
    checkOutput("rst-wait idle ready", 32'(inReady), 32'd1);

    applyStimulus(vecs[0]);
    drainResult(0, vecs[0].expSum, vecs[0].expErr);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sum_req_initiator.md
Name: sum_req_initiator

Overview:
Initiator side of the single-cycle start/valid adder protocol. Accepts operand pairs from an upstream ready/valid stream and issues them to an adder responder as a one-cycle start pulse with a/b. It then waits for the responder's valid, captures y, and returns the result downstream over a ready/valid stream. A bounded wait is enforced: a missing or late valid is reported as a timeout error instead of hanging the pipeline.

Parameters:
W, 12, operand/result width in bits
TIMEOUT, 8, max cycles in WAIT without rsp_valid before timeout (>=2)
CNT_W, $clog2(TIMEOUT+1), width of wait counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  upstream operand pair valid
in_ready  output  1  upstream ready
in_a  input  W  operand a
in_b  input  W  operand b
req_start  output  1  start pulse to responder
req_a  output  W  operand a to responder
req_b  output  W  operand b to responder
rsp_valid  input  1  responder valid
rsp_y  input  W  responder sum
out_valid  output  1  result valid
out_ready  input  1  downstream ready
out_sum  output  W  captured sum (0 on timeout)
out_err  output  1  result is a timeout (or check failure, see feature)
spurious  output  1  sticky: rsp_valid seen outside WAIT

Behaviour:
- Reset (rst_n low at posedge): state=IDLE; req_start=0, req_a=req_b=0, out_valid=0, out_sum=0, out_err=0, spurious=0, counter=0. in_ready = rst_n && state==IDLE, so in_ready=0 while rst_n is low.
- States: IDLE, WAIT, RESP.
- IDLE: on in_valid&&in_ready at edge k: req_a<=in_a, req_b<=in_b, req_start<=1, counter<=0, state<=WAIT. req_start is high exactly one cycle (k to k+1).
- WAIT: req_start<=0. req_a/req_b hold the issued operands until the next accept. The counter increments each edge.
  - rsp_valid at an edge: out_sum<=rsp_y, out_err<=0, out_valid<=1, state<=RESP.
  - Otherwise, if counter==TIMEOUT-1: out_sum<=0, out_err<=1, out_valid<=1, state<=RESP.
  - rsp_valid and timeout on the same edge: rsp_valid wins.
- With a 1-cycle responder: accept at edge k, responder samples start at k+1, rsp_valid is sampled at k+2, and out_valid is high after k+2.
- RESP: out_valid/out_sum/out_err are held stable until out_ready. On out_valid&&out_ready: out_valid<=0, state<=IDLE. in_ready rises the following cycle, so there is one outstanding request maximum.
- rsp_valid sampled in IDLE or RESP sets spurious<=1 (sticky until reset). It never alters out_* or state. A late valid that arrives after a timeout is treated as spurious.
- Sums are W bits and wrap mod 2^W. No carry out; the responder defines y.
- Reset mid-transaction (any state) returns to IDLE with all outputs at reset values. The pending result is dropped.

Optional Feature:
SUM_INIT_CHECK_EN: when defined, the block computes the expected sum req_a+req_b (mod 2^W) locally. On a rsp_valid capture in WAIT, out_err<=(rsp_y != expected) and out_sum<=rsp_y is still returned.
When undefined: no comparator; out_err reflects timeout only.

Test Plan:
- Basic: reset 3 cycles; in_a=0x123, in_b=0x0FF, 1-cycle responder -> req_start one cycle, out_valid 2 cycles after accept, out_sum=0x222, out_err=0.
- Wrap: in_a=0xFFF, in_b=0x002 -> out_sum=0x001, out_err=0.
- Timeout: responder never asserts valid, TIMEOUT=8 -> out_valid after 8 WAIT cycles, out_sum=0, out_err=1. A later rsp_valid sets spurious=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_sum/out_err stable, in_ready=0 throughout. out_ready=1 -> IDLE, in_ready=1 next cycle.
- Boundary: rsp_valid on the same edge as the timeout -> out_err=0, out_sum=rsp_y. Reset asserted in WAIT -> out_valid=0, state IDLE, req_start=0.
- SUM_INIT_CHECK_EN: responder returns 0x300 for 0x100+0x100 -> out_sum=0x300, out_err=1. Correct 0x200 -> out_err=0.
